// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS core (add/sub/and/or/slt, addi, lw, sw, beq, j) on one req/ack memory port; FETCH/MEMRD/MEMWR stall while ack=0.
// Define MIPS_MC_PERF_CNT_EN to add the cycle_cnt/retired_cnt performance counter ports.
module mips_multicycle_core #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TEST_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [TEST_W-1:0] test_value,
  output logic              halted
`ifdef MIPS_MC_PERF_CNT_EN
  ,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       retired_cnt
`endif
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_MEMADR,
    S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  localparam int JW = (ADDR_W > 28) ? ADDR_W : 28;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [31:0]       alu_q, alu_d;
  logic [31:0]       mdr_q, mdr_d;
  logic [31:0]       rf_q [32];
  logic [31:0]       rf_d [32];

  logic [5:0]        opcode, funct;
  logic [4:0]        rs, rt, rd;
  logic [31:0]       imm_sext;
  logic [31:0]       alu_r;
  logic              funct_ok;
  logic [JW-1:0]     pc_ext, jump_ext;
  logic [ADDR_W-1:0] pc_jump;
  logic              req_int;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [31:0]       rf_wdata;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};

  // Jump keeps PC bits above 28 (if any) and truncates for narrow address spaces.
  assign pc_ext   = JW'(pc_q);
  assign jump_ext = (pc_ext & ~JW'(28'hFFF_FFFF)) | JW'({ir_q[25:0], 2'b00});
  assign pc_jump  = ADDR_W'(jump_ext);

  always_comb begin
    alu_r    = '0;
    funct_ok = 1'b1;
    case (funct)
      6'h20:   alu_r = a_q + b_q;
      6'h22:   alu_r = a_q - b_q;
      6'h24:   alu_r = a_q & b_q;
      6'h25:   alu_r = a_q | b_q;
      6'h2A:   alu_r = {31'd0, $signed(a_q) < $signed(b_q)};
      default: funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_d     = alu_q;
    mdr_d     = mdr_q;
    rf_we     = 1'b0;
    rf_waddr  = rd;
    rf_wdata  = alu_q;
    req_int   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = ADDR_W'(alu_q);
    mem_wdata = b_q;
    case (state_q)
      S_FETCH: begin
        req_int  = 1'b1;
        mem_addr = pc_q;
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + ADDR_W'(32'd4);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d   = rf_q[rs];
        b_d   = rf_q[rt];
        alu_d = 32'(pc_q) + (imm_sext << 2);
        case (opcode)
          6'h00:        state_d = S_EXEC_R;
          6'h08:        state_d = S_EXEC_I;
          6'h23, 6'h2B: state_d = S_MEMADR;
          6'h04:        state_d = S_BRANCH;
          6'h02:        state_d = S_JUMP;
          default:      state_d = S_HALT;
        endcase
      end
      S_EXEC_R: begin
        if (funct_ok) begin
          alu_d   = alu_r;
          state_d = S_WB_R;
        end else begin
          state_d = S_HALT;
        end
      end
      S_WB_R: begin
        rf_we   = 1'b1;
        state_d = S_FETCH;
      end
      S_EXEC_I: begin
        alu_d   = a_q + imm_sext;
        state_d = S_WB_I;
      end
      S_WB_I: begin
        rf_we    = 1'b1;
        rf_waddr = rt;
        state_d  = S_FETCH;
      end
      S_MEMADR: begin
        alu_d   = a_q + imm_sext;
        state_d = (opcode == 6'h2B) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        req_int = 1'b1;
        if (mem_ack) begin
          mdr_d   = mem_rdata;
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        rf_we    = 1'b1;
        rf_waddr = rt;
        rf_wdata = mdr_q;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        req_int = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) state_d = S_FETCH;
      end
      S_BRANCH: begin
        if (a_q == b_q) pc_d = ADDR_W'(alu_q);
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_d    = pc_jump;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // $0 is never written, so it reads back as zero.
  always_comb begin
    rf_d = rf_q;
    if (rf_we && (rf_waddr != 5'd0)) rf_d[rf_waddr] = rf_wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      rf_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      rf_q    <= rf_d;
    end
  end

  // Reset abandons any access in flight immediately, not at the next edge.
  assign mem_req    = req_int && !reset;
  assign halted     = (state_q == S_HALT) && !reset;
  assign test_value = rf_q[2][TEST_W-1:0];

`ifdef MIPS_MC_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] retired_cnt_q, retired_cnt_d;
  logic        retire;

  always_comb begin
    retire = (state_q == S_WB_R) || (state_q == S_WB_I) || (state_q == S_MEMWB) ||
             (state_q == S_BRANCH) || (state_q == S_JUMP) ||
             ((state_q == S_MEMWR) && mem_ack);
    cycle_cnt_d   = cycle_cnt_q + ((state_q != S_HALT) ? 32'd1 : 32'd0);
    retired_cnt_d = retired_cnt_q + {31'd0, retire};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_cnt_q   <= '0;
      retired_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign retired_cnt = retired_cnt_q;
`endif

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: instruction-level model predicts every memory transaction,
// its start cycle, test_value and halted; a directed program pins the model with literal values.
module tb_mips_multicycle_core;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, halted;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [15:0] test_value;

  mips_multicycle_core #(.ADDR_W(32), .RESET_PC(32'h0), .TEST_W(16)) dut (
    .clock(clock), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .test_value(test_value), .halted(halted)
  );

  always #5 clock = ~clock;

  localparam int NEVER = 1 << 30;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc;
  logic [31:0] mem [0:127];

  // Instruction-level model state
  logic [31:0] m_rf [0:31];
  logic [31:0] m_pc, m_ir, pend_addr, pend_wdata, tv_old;
  int          pend_kind;  // 0 fetch, 1 load, 2 store
  int          pend_start, halt_cyc, tv_apply, first_halt;

  int          log_cyc [$];
  logic [31:0] log_addr [$];
  logic        log_we [$];

  logic [5:0]  fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  int          dir_cyc [9] = '{0, 4, 8, 11, 12, 15, 17, 20, 23};
  logic [31:0] dir_addr [9] = '{32'h0, 32'h4, 32'h8, 32'h100, 32'hC, 32'h104, 32'h10, 32'h18, 32'h40};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_pc = '0; m_ir = '0; pend_kind = 0; pend_addr = '0; pend_wdata = '0;
    pend_start = 0; halt_cyc = NEVER; tv_old = '0; tv_apply = 0;
  endtask

  // Advance the model by one completed memory transaction accepted in cycle c.
  task automatic model_accept(input int c);
    logic [31:0] ir, sx, rsv, rtv, res;
    logic [5:0]  op, fn;
    logic [4:0]  wa;
    logic        wr;
    int          nxt;
    tv_old = m_rf[2];
    wr = 1'b0; wa = '0; res = '0; nxt = NEVER;
    if (pend_kind == 0) begin
      ir  = mem[pend_addr[8:2]];
      m_pc = m_pc + 32'd4;
      op  = ir[31:26]; fn = ir[5:0];
      sx  = {{16{ir[15]}}, ir[15:0]};
      rsv = m_rf[ir[25:21]]; rtv = m_rf[ir[20:16]];
      if (op == 6'h00) begin
        wr = 1'b1; wa = ir[15:11]; nxt = c + 4;
        case (fn)
          6'h20: res = rsv + rtv;
          6'h22: res = rsv - rtv;
          6'h24: res = rsv & rtv;
          6'h25: res = rsv | rtv;
          6'h2A: res = ($signed(rsv) < $signed(rtv)) ? 32'd1 : 32'd0;
          default: begin wr = 1'b0; nxt = NEVER; halt_cyc = c + 3; end
        endcase
      end else if (op == 6'h08) begin
        wr = 1'b1; wa = ir[20:16]; res = rsv + sx; nxt = c + 4;
      end else if (op == 6'h23) begin
        pend_kind = 1; pend_addr = rsv + sx; m_ir = ir; nxt = c + 3;
      end else if (op == 6'h2B) begin
        pend_kind = 2; pend_addr = rsv + sx; pend_wdata = rtv; nxt = c + 3;
      end else if (op == 6'h04) begin
        if (rsv == rtv) m_pc = m_pc + (sx << 2);
        nxt = c + 3;
      end else if (op == 6'h02) begin
        m_pc = {m_pc[31:28], ir[25:0], 2'b00}; nxt = c + 3;
      end else begin
        halt_cyc = c + 2;
      end
      if (pend_kind == 0) pend_addr = m_pc;
    end else if (pend_kind == 1) begin
      wr = 1'b1; wa = m_ir[20:16]; res = mem[pend_addr[8:2]];
      pend_kind = 0; pend_addr = m_pc; nxt = c + 2;
    end else begin
      mem[pend_addr[8:2]] = pend_wdata;
      pend_kind = 0; pend_addr = m_pc; nxt = c + 1;
    end
    if (wr && wa != 5'd0) m_rf[wa] = res;
    pend_start = nxt;
    tv_apply   = nxt;
  endtask

  task automatic cycle_check();
    logic        e_req, e_halt;
    logic [31:0] e_tv;
    e_halt = (cyc >= halt_cyc);
    e_req  = !e_halt && (cyc >= pend_start);
    e_tv   = (cyc >= tv_apply) ? m_rf[2] : tv_old;
    check("mem_req", mem_req, e_req);
    check("halted", halted, e_halt);
    check("test_value", test_value, e_tv[15:0]);
    if (e_req && mem_req) begin
      check("mem_addr", mem_addr, pend_addr);
      check("mem_we", mem_we, pend_kind == 2);
      if (pend_kind == 2) check("mem_wdata", mem_wdata, pend_wdata);
    end
  endtask

  // Enter reset wherever the core is (possibly mid-access) and hold it with ack=1.
  task automatic do_reset();
    reset = 1'b1; mem_ack = 1'b1;
    #1 check("req_in_reset", mem_req, 1'b0);
    repeat (2) begin
      @(negedge clock);
      #1 check("req_in_reset", mem_req, 1'b0);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic run_round(input int budget, input int wait_pct);
    logic acc, prev_req, prev_acc, model_ready;
    model_reset();
    cyc = 0; prev_req = 1'b0; prev_acc = 1'b0; first_halt = -1;
    log_cyc.delete(); log_addr.delete(); log_we.delete();
    while (cyc < budget && !(halt_cyc != NEVER && cyc > halt_cyc + 3)) begin
      #1;
      cycle_check();
      if (halted && first_halt < 0) first_halt = cyc;
      if (mem_req && (!prev_req || prev_acc)) begin
        log_cyc.push_back(cyc); log_addr.push_back(mem_addr); log_we.push_back(mem_we);
      end
      mem_ack   = ($urandom_range(0, 99) >= wait_pct);
      mem_rdata = (mem_req && !mem_we) ? mem[mem_addr[8:2]] : $urandom();
      acc = mem_req && mem_ack;
      model_ready = (cyc >= pend_start) && (cyc < halt_cyc);
      if (acc && model_ready) model_accept(cyc);
      prev_req = mem_req; prev_acc = acc;
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic gen_program(input bit with_bad);
    int          bad_slot, k, t;
    logic [4:0]  rs, rt, rd;
    logic [15:0] off;
    logic [31:0] w;
    for (int i = 0; i < 128; i++) mem[i] = $urandom();
    bad_slot = with_bad ? $urandom_range(5, 62) : -1;
    for (int i = 0; i < 63; i++) begin
      k  = $urandom_range(0, 99);
      rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
      t  = $urandom_range(0, 62);
      if (k < 30)      w = {6'h00, rs, rt, rd, 5'd0, fns[$urandom_range(0, 4)]};
      else if (k < 45) w = {6'h08, rs, rt, 16'($urandom())};
      else if (k < 60) w = {6'h23, 5'd0, rt, 16'(32'h100 + 4 * $urandom_range(0, 63))};
      else if (k < 72) w = {6'h2B, 5'd0, rt, 16'(32'h100 + 4 * $urandom_range(0, 63))};
      else if (k < 85) begin
        off = 16'(t - i - 1);
        w = {6'h04, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), off};
      end
      else if (k < 93) w = {6'h02, 26'(t)};
      else             w = {6'h08, 5'd0, rt, 16'($urandom_range(0, 9))};
      if (i == bad_slot)
        w = ($urandom_range(0, 1) == 1) ? {6'h3F, 26'($urandom())} : {6'h00, rs, rt, rd, 5'd0, 6'h00};
      mem[i] = w;
    end
    mem[63] = 32'h0800_0000;
  endtask

  initial begin
    @(negedge clock);
    for (int i = 0; i < 128; i++) mem[i] = 32'hFC00_0000;
    mem[0]  = 32'h2002_0005;  // addi $2,$0,5
    mem[1]  = 32'h0042_1820;  // add  $3,$2,$2
    mem[2]  = 32'hAC03_0100;  // sw   $3,0x100($0)
    mem[3]  = 32'h8C02_0104;  // lw   $2,0x104($0)
    mem[4]  = 32'h1000_0001;  // beq  $0,$0,+1
    mem[6]  = 32'h0800_0010;  // j    0x40
    mem[64] = 32'hDEAD_BEEF;
    mem[65] = 32'h0000_1234;
    do_reset();
    run_round(200, 0);
    check("dir_log_len", log_cyc.size(), 9);
    for (int i = 0; i < 9 && i < log_cyc.size(); i++) begin
      check("dir_req_cycle", log_cyc[i], dir_cyc[i]);
      check("dir_req_addr", log_addr[i], dir_addr[i]);
      check("dir_req_we", log_we[i], i == 3);
    end
    check("dir_halt_cycle", first_halt, 25);
    check("dir_test_value", test_value, 16'h1234);
    check("dir_model_r2", m_rf[2], 32'h0000_1234);
    check("dir_model_r3", m_rf[3], 32'd10);
    check("dir_mem_store", mem[64], 32'd10);

    for (int r = 0; r < 6; r++) begin
      gen_program(r >= 3);
      do_reset();
      run_round(1500, r * 12);
    end

    do_reset();
    #1;
    check("post_reset_halted", halted, 1'b0);
    check("post_reset_req", mem_req, 1'b1);
    check("post_reset_addr", mem_addr, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
